// File: rtl/weight_fifo_loader.sv
// Streams a contiguous run of weight words from weight memory into one half of the
// double-buffered weight FIFO. Optional stall counter: WT_LOADER_STALL_CNT_EN.
module weight_fifo_loader #(
    parameter int DATA_WIDTH     = 24,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int CNT_WIDTH      = 13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]      num_words,
    input  logic                      buf_sel,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rd_data,
    output logic                      wt_buf_sel,
    output logic                      wr_en,
    output logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      wr_full,
    output logic [15:0]               stall_cycles
);

    typedef enum logic [2:0] {IDLE, SETUP, FETCH, DRAIN, FIN} state_t;

    state_t                    state, state_nxt;
    logic [MEM_ADDR_WIDTH-1:0] base_q;
    logic [CNT_WIDTH-1:0]      num_q;
    logic [CNT_WIDTH-1:0]      issued;
    logic [CNT_WIDTH-1:0]      pushed;
    logic                      sel_q;
    logic                      rd_vld_p1;
    logic [DATA_WIDTH-1:0]     skid_q0;
    logic [DATA_WIDTH-1:0]     skid_q1;
    logic [1:0]                skid_cnt;
    logic [2:0]                occ;
    logic                      accept;
    logic                      issue;
    logic                      push;

    assign accept = (state == IDLE) && start;
    assign push   = ((state == FETCH) || (state == DRAIN)) && (skid_cnt != 2'd0) && !wr_full;

    // The slot freed by a push in this cycle is reusable at once, which keeps one word
    // per cycle flowing while never holding more than two words between memory and FIFO.
    assign occ   = {1'b0, skid_cnt} + {2'b00, rd_vld_p1} - {2'b00, push};
    assign issue = (state == FETCH) && (issued != num_q) && (occ < 3'd2);

    assign busy       = (state != IDLE);
    assign done       = (state == FIN);
    assign mem_rd_en  = issue;
    assign mem_addr   = base_q + MEM_ADDR_WIDTH'(issued);
    assign wt_buf_sel = sel_q;
    assign wr_en      = push;
    assign wr_data    = skid_q0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   state_nxt = (num_q == '0) ? FIN : FETCH;
            FETCH:   if (issued == num_q) state_nxt = DRAIN;
            DRAIN:   if ((pushed + CNT_WIDTH'(push)) == num_q) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base_q    <= '0;
            num_q     <= '0;
            sel_q     <= 1'b0;
            issued    <= '0;
            pushed    <= '0;
            rd_vld_p1 <= 1'b0;
            skid_q0   <= '0;
            skid_q1   <= '0;
            skid_cnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                base_q <= base_addr;
                num_q  <= num_words;
                sel_q  <= buf_sel;
                issued <= '0;
                pushed <= '0;
            end else begin
                if (issue) issued <= issued + CNT_WIDTH'(1);
                if (push)  pushed <= pushed + CNT_WIDTH'(1);
            end

            // memory read stage -> skid stage
            rd_vld_p1 <= issue;
            case ({rd_vld_p1, push})
                2'b10: begin
                    if (skid_cnt == 2'd0) skid_q0 <= mem_rd_data;
                    else                  skid_q1 <= mem_rd_data;
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid_q0  <= skid_q1;
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid_q0 <= mem_rd_data;
                    end else begin
                        skid_q0 <= skid_q1;
                        skid_q1 <= mem_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WT_LOADER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 16'h0000;
        end else if (accept) begin
            stall_q <= 16'h0000;
        end else if (busy && (skid_cnt != 2'd0) && wr_full && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule
